// File: rtl/trig_quadrant_reconstructor_pkg.sv
// trig_quadrant_reconstructor_pkg: quadrant encoding and float constants shared by the range reducer and the reconstructor
package trig_quadrant_reconstructor_pkg;
  typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quad_e;
  localparam int SIGN_BIT = 31;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  // Negating either signed zero gives +0; NaN and Inf only flip their sign.
  function automatic logic [31:0] fp_neg(input logic [31:0] x);
    return x[SIGN_BIT-1:0] == '0 ? FP_ZERO : {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: quadrant-tag FIFO with occupancy count and pointers that wrap modulo DEPTH
module tag_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [1:0]               din,
  input  logic                     pop,
  output logic [1:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clock)
    if (push) mem[wptr] <= din;
  assign dout = mem[rptr];
endmodule

// File: rtl/trig_quadrant_reconstructor.sv
// trig_quadrant_reconstructor: rebuilds sin/cos of the original angle from reduced-angle results and queued quadrant tags
module trig_quadrant_reconstructor
  import trig_quadrant_reconstructor_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_tag_valid,
  input  logic [1:0]             io_tag_quad,
  output logic                   io_tag_ready,
  input  logic                   io_in_valid,
  input  logic [31:0]            io_in_sin,
  input  logic [31:0]            io_in_cos,
  output logic                   io_in_ready,
  output logic [31:0]            io_out_sin,
  output logic [31:0]            io_out_cos,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [$clog2(DEPTH):0] io_count,
  output logic                   io_err_underflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic        push;
  logic        accept;
  logic [1:0]  head;
  quad_e       q;
  logic [31:0] neg_s;
  logic [31:0] neg_c;
  logic [31:0] map_sin;
  logic [31:0] map_cos;
  // Readiness uses the registered count only, so a same-cycle pop never opens room for a push.
  assign io_tag_ready = io_count < CW'(DEPTH);
  assign io_in_ready  = (io_count != '0) && (!io_out_valid || io_out_ready);
  assign push         = io_tag_valid && io_tag_ready;
  assign accept       = io_in_valid && io_in_ready;
  tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (io_tag_quad),
    .pop   (accept),
    .dout  (head),
    .count (io_count)
  );
  always_comb begin
    q       = quad_e'(head);
    neg_s   = fp_neg(io_in_sin);
    neg_c   = fp_neg(io_in_cos);
    map_sin = q == Q0 ? io_in_sin : q == Q1 ? io_in_cos : q == Q2 ? neg_s : neg_c;
    map_cos = q == Q0 ? io_in_cos : q == Q1 ? neg_s : q == Q2 ? neg_c : io_in_sin;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      io_out_sin       <= FP_ZERO;
      io_out_cos       <= FP_ZERO;
      io_out_valid     <= 1'b0;
      io_err_underflow <= 1'b0;
    end else begin
      if (accept) begin
        io_out_sin   <= map_sin;
        io_out_cos   <= map_cos;
        io_out_valid <= 1'b1;
      end else if (io_out_ready) begin
        io_out_valid <= 1'b0;
      end
      if (io_in_valid && io_count == '0) io_err_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_trig_quadrant_reconstructor.sv
// tb_trig_quadrant_reconstructor: directed and randomized checks against a queue-based reference model
module tb_trig_quadrant_reconstructor;
  localparam int DEPTH = 16;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_tag_valid = 1'b0;
  logic [1:0]  io_tag_quad = 2'd0;
  logic        io_tag_ready;
  logic        io_in_valid = 1'b0;
  logic [31:0] io_in_sin = '0;
  logic [31:0] io_in_cos = '0;
  logic        io_in_ready;
  logic [31:0] io_out_sin;
  logic [31:0] io_out_cos;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [$clog2(DEPTH):0] io_count;
  logic        io_err_underflow;

  trig_quadrant_reconstructor #(.DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_tag_valid     (io_tag_valid),
    .io_tag_quad      (io_tag_quad),
    .io_tag_ready     (io_tag_ready),
    .io_in_valid      (io_in_valid),
    .io_in_sin        (io_in_sin),
    .io_in_cos        (io_in_cos),
    .io_in_ready      (io_in_ready),
    .io_out_sin       (io_out_sin),
    .io_out_cos       (io_out_cos),
    .io_out_valid     (io_out_valid),
    .io_out_ready     (io_out_ready),
    .io_count         (io_count),
    .io_err_underflow (io_err_underflow)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] neg(input logic [31:0] x);
    return (x & 32'h7fff_ffff) == 32'h0 ? 32'h0 : x ^ 32'h8000_0000;
  endfunction

  // Reference model: the tag queue plus the expected output register contents.
  int          tags[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_sin = '0;
  logic [31:0] m_cos = '0;
  logic        m_err = 1'b0;
  bit          tr;
  bit          ir;
  int          qq;

  always @(negedge clock) begin
    if (!reset) begin
      tags.delete();
      m_valid = 1'b0;
      m_sin = '0;
      m_cos = '0;
      m_err = 1'b0;
      check("rst_count", 32'(io_count), 32'd0);
      check("rst_valid", 32'(io_out_valid), 32'd0);
      check("rst_tag_ready", 32'(io_tag_ready), 32'd1);
      check("rst_in_ready", 32'(io_in_ready), 32'd0);
      check("rst_err", 32'(io_err_underflow), 32'd0);
      check("rst_sin", io_out_sin, 32'd0);
      check("rst_cos", io_out_cos, 32'd0);
    end else begin
      tr = tags.size() < DEPTH;
      ir = tags.size() > 0 && (!m_valid || io_out_ready);
      check("tag_ready", 32'(io_tag_ready), 32'(tr));
      check("in_ready", 32'(io_in_ready), 32'(ir));
      check("out_valid", 32'(io_out_valid), 32'(m_valid));
      check("count", 32'(io_count), 32'(tags.size()));
      check("err", 32'(io_err_underflow), 32'(m_err));
      check("out_sin", io_out_sin, m_sin);
      check("out_cos", io_out_cos, m_cos);
      if (io_in_valid && tags.size() == 0) m_err = 1'b1;
      if (io_in_valid && ir) begin
        qq = tags.pop_front();
        case (qq)
          0: begin m_sin = io_in_sin;      m_cos = io_in_cos;      end
          1: begin m_sin = io_in_cos;      m_cos = neg(io_in_sin); end
          2: begin m_sin = neg(io_in_sin); m_cos = neg(io_in_cos); end
          default: begin m_sin = neg(io_in_cos); m_cos = io_in_sin; end
        endcase
        m_valid = 1'b1;
      end else if (io_out_ready) begin
        m_valid = 1'b0;
      end
      if (io_tag_valid && tr) tags.push_back(int'(io_tag_quad));
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_tag(input logic [1:0] q);
    io_tag_valid = 1'b1;
    io_tag_quad = q;
    tick();
    io_tag_valid = 1'b0;
  endtask

  task automatic give(input logic [31:0] s, input logic [31:0] c);
    io_in_valid = 1'b1;
    io_in_sin = s;
    io_in_cos = c;
    tick();
    io_in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [31:0] specials [4];
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7f80_0000, 32'hffc0_0000};
    return ($urandom % 4 == 0) ? specials[$urandom % 4] : $urandom;
  endfunction

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    push_tag(2'd1);
    check("lat_pre_valid", 32'(io_out_valid), 32'd0);
    give(32'h3F00_0000, 32'h3F5D_B3D7);
    check("q1_valid", 32'(io_out_valid), 32'd1);
    check("q1_sin", io_out_sin, 32'h3F5D_B3D7);
    check("q1_cos", io_out_cos, 32'hBF00_0000);
    tick();
    push_tag(2'd2);
    push_tag(2'd3);
    give(32'h3F00_0000, 32'h0000_0000);
    check("q2_sin", io_out_sin, 32'hBF00_0000);
    check("q2_cos", io_out_cos, 32'h0000_0000);
    give(32'h0000_0000, 32'h3F80_0000);
    check("q3_sin", io_out_sin, 32'hBF80_0000);
    check("q3_cos", io_out_cos, 32'h0000_0000);
    tick();
    push_tag(2'd1);
    give(32'h8000_0000, 32'h3F80_0000);
    check("negzero_sin", io_out_sin, 32'h3F80_0000);
    check("negzero_cos", io_out_cos, 32'h0000_0000);
    tick();
    give(32'h1234_5678, 32'h9abc_def0);
    check("uflow_err", 32'(io_err_underflow), 32'd1);
    check("uflow_count", 32'(io_count), 32'd0);
    check("uflow_valid", 32'(io_out_valid), 32'd0);
    tick();
    check("uflow_sticky", 32'(io_err_underflow), 32'd1);
    io_tag_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      io_tag_quad = 2'($urandom);
      tick();
    end
    check("full_count", 32'(io_count), 32'(DEPTH));
    check("full_tag_ready", 32'(io_tag_ready), 32'd0);
    io_in_valid = 1'b1;
    io_in_sin = $urandom;
    io_in_cos = $urandom;
    tick();
    io_tag_valid = 1'b0;
    check("full_pop_push", 32'(io_count), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++) begin
      io_in_sin = $urandom;
      io_in_cos = $urandom;
      tick();
    end
    io_in_valid = 1'b0;
    check("drained", 32'(io_count), 32'd0);
    tick();
    push_tag(2'd0);
    push_tag(2'd2);
    give(32'h3F80_0000, 32'h4000_0000);
    io_out_ready = 1'b0;
    io_in_valid = 1'b1;
    io_in_sin = 32'h4040_0000;
    io_in_cos = 32'h4080_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_in_ready", 32'(io_in_ready), 32'd0);
      check("stall_sin", io_out_sin, 32'h3F80_0000);
    end
    io_out_ready = 1'b1;
    tick();
    io_in_valid = 1'b0;
    check("stall_next_sin", io_out_sin, 32'hC040_0000);
    tick();
    for (int i = 0; i < 6; i++) push_tag(2'($urandom));
    io_out_ready = 1'b0;
    give(32'h3F00_0000, 32'h3F00_0000);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    check("async_count", 32'(io_count), 32'd0);
    check("async_valid", 32'(io_out_valid), 32'd0);
    check("async_sin", io_out_sin, 32'd0);
    io_out_ready = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (3000) begin
      io_tag_valid = 1'($urandom);
      io_tag_quad = 2'($urandom);
      io_in_valid = ($urandom % 4) != 0;
      io_out_ready = ($urandom % 4) != 0;
      io_in_sin = rnd_fp();
      io_in_cos = rnd_fp();
      tick();
    end
    io_tag_valid = 1'b0;
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
